// File: rtl/instr_encoder.sv
// instr_encoder: packs symbolic MIPS-32 instructions into words and streams them into instruction memory via a FIFO.
module instr_encoder #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [4:0]        op_sel,
  input  logic [4:0]        rs,
  input  logic [4:0]        rt,
  input  logic [4:0]        rd,
  input  logic [4:0]        shamt,
  input  logic [15:0]       imm,
  input  logic [25:0]       target,
  output logic              wr_en,
  input  logic              wr_ready,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic [15:0]       wr_count,
  output logic              err,
  input  logic              err_clr
);
  localparam int PW = $clog2(DEPTH);
  logic [31:0] mem [DEPTH];
  logic [PW:0] wp, rp;
  logic [5:0] fn, opc;
  logic [4:0] f_rs, f_rt, f_rd, f_sh;
  logic [31:0] word;
  logic shift, r_type, j_type, legal, full, empty, acc, push, pop;
  always_comb begin
    fn = 6'd0;
    opc = 6'd0;
    case (op_sel) inside
      5'd1: fn = 6'd2;
      5'd2: fn = 6'd3;
      5'd3: fn = 6'd4;
      5'd4: fn = 6'd6;
      5'd5: fn = 6'd7;
      5'd6: fn = 6'd8;
      5'd7: fn = 6'd9;
      [5'd8:5'd15]: fn = {1'b0, op_sel} + 6'd24;
      5'd16: fn = 6'd42;
      5'd17: fn = 6'd43;
      [5'd18:5'd24]: opc = {1'b0, op_sel} - 6'd10;
      5'd25: opc = 6'd35;
      5'd26: opc = 6'd43;
      5'd27: opc = 6'd4;
      5'd28: opc = 6'd5;
      5'd29: opc = 6'd2;
      5'd30: opc = 6'd3;
      default: ;
    endcase
  end
  assign shift  = op_sel < 5'd3;
  assign r_type = op_sel < 5'd18;
  assign j_type = op_sel == 5'd29 || op_sel == 5'd30;
  assign legal  = op_sel != 5'd31;
  // jr (6) and jalr (7) drop rt; jr also drops rd
  assign f_rs = shift ? 5'd0 : rs;
  assign f_rt = (op_sel == 5'd6 || op_sel == 5'd7) ? 5'd0 : rt;
  assign f_rd = op_sel == 5'd6 ? 5'd0 : rd;
  assign f_sh = shift ? shamt : 5'd0;
  assign word = r_type ? {6'd0, f_rs, f_rt, f_rd, f_sh, fn} : j_type ? {opc, target} : {opc, rs, rt, imm};
  assign full     = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  assign empty    = wp == rp;
  assign in_ready = !full;
  assign acc      = in_valid && !full;
  assign push     = acc && legal;
  assign pop      = !empty && wr_ready;
  assign wr_en    = !empty;
  assign wr_data  = empty ? 32'd0 : mem[rp[PW-1:0]];
  always_ff @(posedge clk)
    if (push) mem[wp[PW-1:0]] <= word;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp <= '0;
      rp <= '0;
      wr_addr <= BASE_ADDR;
      wr_count <= '0;
      err <= 1'b0;
    end else begin
      if (push) wp <= wp + 1'b1;
      if (pop) begin
        rp <= rp + 1'b1;
        wr_addr <= wr_addr + ADDR_W'(4);
        wr_count <= wr_count + 16'd1;
      end
      err <= (acc && !legal) || (err && !err_clr);
    end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: table vectors, directed corner sequences and random traffic against a queue-based reference model.
module tb_instr_encoder;
  localparam int DEPTH = 4;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 0, in_ready, wr_en, wr_ready = 0, err, err_clr = 0;
  logic [4:0] op_sel = 0, rs = 0, rt = 0, rd = 0, shamt = 0;
  logic [15:0] imm = 0;
  logic [25:0] target = 0;
  logic [31:0] wr_addr, wr_data;
  logic [15:0] wr_count;
  logic v2 = 0, rdy2 = 0, ir2, en2, err2;
  logic [7:0] addr2;
  logic [31:0] data2;
  logic [15:0] cnt2;
  int n_chk = 0, n_fail = 0, acc_n;
  logic [31:0] q[$];
  logic [31:0] m_addr = 0;
  logic [15:0] m_cnt = 0;
  logic m_err = 0;
  int unsigned r_fn [18] = '{0, 2, 3, 4, 6, 7, 8, 9, 32, 33, 34, 35, 36, 37, 38, 39, 42, 43};
  int unsigned i_op [11] = '{8, 9, 10, 11, 12, 13, 14, 35, 43, 4, 5};
  typedef struct {
    logic [4:0] op, s, t, d, h;
    logic [15:0] im;
    logic [25:0] tg;
    logic [31:0] exp;
  } vec_t;
  vec_t tbl [8];

  always #5 clk = ~clk;

  instr_encoder #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .wr_en(wr_en), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_count(wr_count), .err(err), .err_clr(err_clr));

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(8'hF8)) u_w (
    .clk(clk), .rst(rst), .in_valid(v2), .in_ready(ir2), .op_sel(op_sel),
    .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .imm(imm), .target(target),
    .wr_en(en2), .wr_ready(rdy2), .wr_addr(addr2), .wr_data(data2),
    .wr_count(cnt2), .err(err2), .err_clr(err_clr));

  function automatic logic [31:0] enc(int unsigned op, int unsigned s, int unsigned t,
                                      int unsigned d, int unsigned h, int unsigned im, int unsigned tg);
    if (op < 3) return 32'((t << 16) | (d << 11) | (h << 6) | r_fn[op]);
    if (op == 6) return 32'((s << 21) | 8);
    if (op == 7) return 32'((s << 21) | (d << 11) | 9);
    if (op < 18) return 32'((s << 21) | (t << 16) | (d << 11) | r_fn[op]);
    if (op < 29) return 32'((i_op[op - 18] << 26) | (s << 21) | (t << 16) | im);
    return 32'(((op - 27) << 26) | tg);
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic rnd_in(int max_op);
    op_sel = 5'($urandom_range(0, max_op));
    rs = 5'($urandom);
    rt = 5'($urandom);
    rd = 5'($urandom);
    shamt = 5'($urandom);
    imm = 16'($urandom);
    target = 26'($urandom);
  endtask

  task automatic step();
    bit full_m, acc_m;
    full_m = q.size() == DEPTH;
    acc_m = in_valid && !full_m;
    chk("in_ready", in_ready, !full_m);
    chk("wr_en", wr_en, q.size() != 0);
    if (q.size() != 0) chk("wr_data", wr_data, q[0]);
    chk("wr_addr", wr_addr, m_addr);
    chk("wr_count", wr_count, m_cnt);
    chk("err", err, m_err);
    if (wr_ready && q.size() != 0) begin
      void'(q.pop_front());
      m_addr += 4;
      m_cnt++;
    end
    if (acc_m && op_sel != 31) q.push_back(enc(op_sel, rs, rt, rd, shamt, imm, target));
    m_err = (acc_m && op_sel == 31) ? 1'b1 : err_clr ? 1'b0 : m_err;
    @(negedge clk);
  endtask

  initial begin
    tbl[0] = '{5'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0, 32'h00221820};
    tbl[1] = '{5'd0, 5'd7, 5'd5, 5'd4, 5'd3, 16'h0, 26'h0, 32'h000520C0};
    tbl[2] = '{5'd18, 5'd1, 5'd2, 5'd9, 5'd9, 16'hFFFF, 26'h0, 32'h2022FFFF};
    tbl[3] = '{5'd25, 5'd29, 5'd8, 5'd0, 5'd0, 16'h4, 26'h0, 32'h8FA80004};
    tbl[4] = '{5'd29, 5'd3, 5'd3, 5'd3, 5'd3, 16'h1234, 26'h100, 32'h08000100};
    tbl[5] = '{5'd6, 5'd31, 5'd5, 5'd6, 5'd2, 16'h0, 26'h0, 32'h03E00008};
    tbl[6] = '{5'd7, 5'd4, 5'd5, 5'd31, 5'd7, 16'h0, 26'h0, 32'h0080F809};
    tbl[7] = '{5'd27, 5'd3, 5'd4, 5'd1, 5'd1, 16'h8000, 26'h0, 32'h10648000};
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_wr_count", wr_count, 0);
    chk("rst_err", err, 0);
    @(negedge clk);
    rst = 0;
    wr_ready = 1;
    for (int i = 0; i < 8; i++) begin
      {op_sel, rs, rt, rd, shamt, imm, target} = {tbl[i].op, tbl[i].s, tbl[i].t, tbl[i].d, tbl[i].h, tbl[i].im, tbl[i].tg};
      in_valid = 1;
      step();
      in_valid = 0;
      chk("tbl_word", wr_data, tbl[i].exp);
      chk("tbl_addr", wr_addr, 32'(4 * i));
      step();
    end
    chk("tbl_count", wr_count, 8);
    wr_ready = 0;
    acc_n = 0;
    for (int i = 0; i < 6; i++) begin
      rnd_in(30);
      in_valid = 1;
      if (in_ready) acc_n++;
      step();
    end
    in_valid = 0;
    chk("bp_accepts", acc_n, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    step();
    wr_ready = 1;
    repeat (6) step();
    in_valid = 1;
    repeat (10) begin
      rnd_in(30);
      step();
    end
    in_valid = 0;
    repeat (2) step();
    op_sel = 31;
    in_valid = 1;
    step();
    in_valid = 0;
    chk("ill_err", err, 1);
    chk("ill_no_write", wr_en, 0);
    in_valid = 1;
    err_clr = 1;
    step();
    in_valid = 0;
    chk("ill_set_wins", err, 1);
    step();
    err_clr = 0;
    chk("ill_cleared", err, 0);
    repeat (400) begin
      rnd_in(31);
      in_valid = ($urandom % 4) != 0;
      wr_ready = ($urandom % 3) != 0;
      err_clr = ($urandom % 8) == 0;
      step();
    end
    in_valid = 0;
    err_clr = 1;
    wr_ready = 1;
    repeat (6) step();
    err_clr = 0;
    {op_sel, rs, rt, rd} = {5'd8, 5'd1, 5'd2, 5'd3};
    v2 = 1;
    repeat (3) @(negedge clk);
    v2 = 0;
    rdy2 = 1;
    chk("wrap_en", en2, 1);
    chk("wrap_a0", addr2, 8'hF8);
    @(negedge clk);
    chk("wrap_a1", addr2, 8'hFC);
    @(negedge clk);
    chk("wrap_a2", addr2, 8'h00);
    @(negedge clk);
    wr_ready = 0;
    in_valid = 1;
    repeat (3) begin
      rnd_in(30);
      step();
    end
    in_valid = 0;
    chk("pre_rst_en", wr_en, 1);
    #2 rst = 1;
    #1;
    chk("async_wr_en", wr_en, 0);
    chk("async_wr_addr", wr_addr, 0);
    chk("async_in_ready", in_ready, 1);
    chk("async_wr_count", wr_count, 0);
    q.delete();
    m_addr = 0;
    m_cnt = 0;
    m_err = 0;
    @(negedge clk);
    rst = 0;
    wr_ready = 1;
    repeat (4) step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/instr_encoder.md
# instr_encoder

Instruction encoder and instruction-memory loader for the MIPS-32 core; the inverse of the control decoder. Accepts one symbolic instruction per handshake (mnemonic select plus register, shamt, immediate and target fields) and packs it into a 32-bit MIPS word. Words are buffered in a small FIFO and streamed as sequential word writes into instruction memory, for boot loading and self-test program generation.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- ADDR_W, 32, width of the byte address written to instruction memory
- BASE_ADDR, 0, first write address; must be word aligned

- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  encoder can accept a request
- op_sel  in  5  mnemonic select; see Operation
- rs, rt, rd, shamt  in  5 each  register and shift fields
- imm  in  16  immediate or branch offset
- target  in  26  jump target field
- wr_en  out  1  write request to instruction memory
- wr_ready  in  1  memory accepts the write this cycle
- wr_addr  out  ADDR_W  byte address of the current write
- wr_data  out  32  encoded instruction word
- wr_count  out  16  number of completed writes; wraps modulo 2^16
- err  out  1  sticky flag: an illegal op_sel was accepted
- err_clr  in  1  synchronous clear of err

## Operation
- **op_sel map, R-type** (opcode 000000, funct in parentheses):
  - 0 sll (000000), 1 srl (000010), 2 sra (000011)
  - 3 sllv (000100), 4 srlv (000110), 5 srav (000111)
  - 6 jr (001000), 7 jalr (001001)
  - 8 add (100000), 9 addu (100001), 10 sub (100010), 11 subu (100011)
  - 12 and (100100), 13 or (100101), 14 xor (100110), 15 nor (100111)
  - 16 slt (101010), 17 sltu (101011)
- **op_sel map, I-type** (opcode in parentheses): 18 addi (001000), 19 addiu (001001), 20 slti (001010), 21 sltiu (001011), 22 andi (001100), 23 ori (001101), 24 xori (001110), 25 lw (100011), 26 sw (101011), 27 beq (000100), 28 bne (000101).
- **op_sel map, J-type**: 29 j (000010), 30 jal (000011).
- **op_sel 31** is illegal.
- **R word**: {000000, rs, rt, rd, shamt, funct}.
  - sll/srl/sra: rs field forced to 0.
  - All other R ops: shamt forced to 0.
  - jr: rt, rd and shamt forced to 0.
  - jalr: rt and shamt forced to 0; rd passed through.
- **I word**: {opcode, rs, rt, imm}; imm is copied verbatim, with no sign handling.
- **J word**: {opcode, target}.
- **Accept**: in_valid && in_ready at a rising edge.
  - A legal request is encoded combinationally and the word is pushed into the FIFO on that edge.
  - An illegal request completes the handshake, pushes nothing and sets err.
- **in_ready** = FIFO not full. It depends only on the full flag, so there is no push while full even if a pop occurs in the same cycle.
- **Write side**:
  - wr_en = FIFO not empty; wr_data = FIFO head.
  - wr_addr = address counter.
  - When wr_en && wr_ready: pop the head, add 4 to the address (wrapping modulo 2^ADDR_W), and increment wr_count.
  - While wr_ready is low, wr_en, wr_data and wr_addr hold stable.
- **Simultaneous push and pop** (FIFO not full, not empty): occupancy is unchanged and word order is preserved.
- **err**:
  - Set on an illegal accept.
  - err_clr clears it at the next edge.
  - If both happen in the same cycle, set wins.
- **Reset**: at any time, including mid-stream, reset discards all FIFO contents.
  - Outputs after reset: wr_en=0, in_ready=1, wr_addr=BASE_ADDR, wr_data=0, wr_count=0, err=0.

## Timing
- Latency from accept to first wr_en assertion for that word: 1 cycle when the FIFO was empty.
- Throughput: one word per cycle with wr_ready held high and in_valid held high. The FIFO never fills in that case.
- With wr_ready held low, exactly DEPTH requests are accepted. in_ready deasserts in the cycle after the DEPTH-th accept.
- After a pop from a full FIFO, in_ready reasserts in the next cycle.
- Reset is asynchronous on assertion. Outputs take their reset values immediately, with no clock edge needed.

## Test plan
- add with rs=1, rt=2, rd=3 -> wr_data=0x00221820 at wr_addr=BASE_ADDR; wr_en high 1 cycle after accept; wr_count becomes 1.
- Field forcing and formats:
  - sll with rs=7, rt=5, rd=4, shamt=3 -> 0x000520C0
  - addi with rs=1, rt=2, imm=0xFFFF -> 0x2022FFFF
  - lw with rs=29, rt=8, imm=4 -> 0x8FA80004
  - j with target=0x100 -> 0x08000100
  - Consecutive words go to addresses +0, +4, +8, +12.
- Back-pressure: hold wr_ready=0 and offer 6 requests -> exactly 4 accepted and in_ready=0. Then set wr_ready=1 -> 4 writes in order, with wr_data stable while stalled.
- Illegal op: op_sel=31 accepted -> no write, err=1, FIFO unchanged. Assert err_clr and an illegal accept in the same cycle -> err stays 1. err_clr alone -> err=0.
- Address wrap: ADDR_W=8, BASE_ADDR=0xF8, three writes -> wr_addr 0xF8, 0xFC, 0x00.
- Reset mid-stream: 3 words queued with wr_ready=0, assert rst between edges -> wr_en=0 and wr_addr=BASE_ADDR immediately. After release there are no stale writes and in_ready=1.
